// File: rtl/piano_pkg.sv
// Shared mode codes, commit FSM states and classification helpers for the piano mode path.
package piano_pkg;
  localparam int NUM_SW = 3;

  localparam logic [NUM_SW-1:0] FREE_MODE      = 3'b001;
  localparam logic [NUM_SW-1:0] AUTO_PLAY_MODE = 3'b010;
  localparam logic [NUM_SW-1:0] LEARNING_MODE  = 3'b100;
  localparam logic [NUM_SW-1:0] WRONG_STATE    = 3'b000;

  typedef enum logic [1:0] {S_NONE, S_ACTIVE, S_ARM} commit_state_t;

  function automatic logic is_onehot(input logic [NUM_SW-1:0] v);
    return $countones(v) == 1;
  endfunction

  function automatic logic is_multi(input logic [NUM_SW-1:0] v);
    return $countones(v) >= 2;
  endfunction
endpackage

// File: rtl/mode_input_conditioner_if.sv
// Switch inputs and conditioned mode outputs; master drives switches, slave is the conditioner.
interface mode_input_conditioner_if;
  import piano_pkg::*;
  logic [NUM_SW-1:0] sw_raw;
  logic              mode_lock;
  logic [NUM_SW-1:0] mode_sel;
  logic              mode_change;
  logic              err_multi;

  modport master (output sw_raw, mode_lock, input mode_sel, mode_change, err_multi);
  modport slave  (input sw_raw, mode_lock, output mode_sel, mode_change, err_multi);
endinterface

// File: rtl/debounce_bit.sv
// One switch bit: 2-FF synchroniser followed by a mismatch-run debouncer.
module debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 2_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic db
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      cnt  <= '0;
      db   <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      // any agreement restarts the run, so short glitches never reach db
      if (sync[1] == db) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        db  <= sync[1];
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/mode_input_conditioner.sv
// Debounces three mode switches and commits a settled one-hot selection as mode_sel.
module mode_input_conditioner
  import piano_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 2_000_000,
  parameter int SETTLE_CYCLES   = 16
) (
  input logic clk,
  input logic rst,
  mode_input_conditioner_if.slave bus
);
  localparam int SCW = $clog2(SETTLE_CYCLES + 1);

  logic [NUM_SW-1:0] db;
  for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
    debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk (clk),
      .rst (rst),
      .raw (bus.sw_raw[i]),
      .db  (db[i])
    );
  end

  commit_state_t     state, state_n;
  logic [NUM_SW-1:0] cand, cand_n, sel, sel_n;
  logic [SCW-1:0]    scnt, scnt_n;
  logic              chg, chg_n, err;
  logic              valid, lock;

  assign valid = is_onehot(db);
  assign lock  = bus.mode_lock;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_NONE;
      cand  <= '0;
      scnt  <= '0;
      sel   <= WRONG_STATE;
      chg   <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      cand  <= cand_n;
      scnt  <= scnt_n;
      sel   <= sel_n;
      chg   <= chg_n;
      err   <= is_multi(db);
    end
  end

  always_comb begin
    state_n = state;
    cand_n  = cand;
    scnt_n  = scnt;
    sel_n   = sel;
    chg_n   = 1'b0;
    case (state)
      S_NONE: if (valid && !lock) begin
        cand_n  = db;
        scnt_n  = '0;
        state_n = S_ARM;
      end
      S_ACTIVE: if (valid && db != sel && !lock) begin
        cand_n  = db;
        scnt_n  = '0;
        state_n = S_ARM;
      end
      S_ARM: begin
        // lock in the commit cycle aborts, so a frozen mode never changes underneath the song
        if (db != cand || lock) state_n = (sel != WRONG_STATE) ? S_ACTIVE : S_NONE;
        else if (scnt == SCW'(SETTLE_CYCLES - 1)) begin
          sel_n   = cand;
          chg_n   = 1'b1;
          state_n = S_ACTIVE;
        end else scnt_n = scnt + 1'b1;
      end
      default: state_n = S_NONE;
    endcase
  end

  assign bus.mode_sel    = sel;
  assign bus.mode_change = chg;
  assign bus.err_multi   = err;
endmodule

// File: tb/tb_mode_input_conditioner.sv
// Directed bench for mode_input_conditioner with a timestamp/window reference model checked every cycle.
module tb_mode_input_conditioner;
  import piano_pkg::*;

  localparam int DB = 4;
  localparam int ST = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mode_input_conditioner_if bus();

  mode_input_conditioner #(.DEBOUNCE_CYCLES(DB), .SETTLE_CYCLES(ST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vec = 0;
  int bad = 0;

  // Reference: a bit flips once the last DB synced samples all disagree with it;
  // a candidate commits ST edges after it was armed if nothing disturbed it.
  typedef struct {
    logic [2:0]          s0, s1;
    logic [DB-1:0][2:0]  hist;
    logic [2:0]          db, sel, cand;
    logic                chg, err, armed;
    int                  arm_t, t;
  } mdl_t;

  mdl_t m;
  bit   live = 1'b0;

  function automatic mdl_t step(mdl_t c, logic r, logic [2:0] raw, logic lk);
    mdl_t n;
    logic flip;
    n     = c;
    n.t   = c.t + 1;
    n.chg = 1'b0;
    if (r) begin
      n.s0 = '0; n.s1 = '0; n.hist = '0; n.db = '0; n.sel = '0; n.cand = '0;
      n.err = 1'b0; n.armed = 1'b0; n.arm_t = 0;
      return n;
    end
    n.s0   = raw;
    n.s1   = c.s0;
    n.hist = {c.hist[DB-2:0], c.s1};
    for (int b = 0; b < 3; b++) begin
      flip = 1'b1;
      for (int k = 0; k < DB; k++) if (n.hist[k][b] == c.db[b]) flip = 1'b0;
      if (flip) n.db[b] = ~c.db[b];
    end
    n.err = ($countones(c.db) >= 2);
    if (c.armed) begin
      if (c.db != c.cand || lk) n.armed = 1'b0;
      else if (c.t - c.arm_t == ST) begin
        n.sel   = c.cand;
        n.chg   = 1'b1;
        n.armed = 1'b0;
      end
    end else if ($countones(c.db) == 1 && !lk && c.db != c.sel) begin
      n.armed = 1'b1;
      n.arm_t = c.t;
      n.cand  = c.db;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m <= step(m, rst, bus.sw_raw, bus.mode_lock);
    if (rst) live <= 1'b1;
  end

  task automatic check(input string nm, input logic [2:0] act, input logic [2:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b, expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (live) begin
      check("model sel", bus.mode_sel, m.sel);
      check("model chg", {2'b0, bus.mode_change}, {2'b0, m.chg});
      check("model err", {2'b0, bus.err_multi}, {2'b0, m.err});
    end
  end

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.sw_raw    = WRONG_STATE;
    bus.mode_lock = 1'b0;
    rst           = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // 1: idle after reset
    edges(20);
    check("t1 sel", bus.mode_sel, WRONG_STATE);
    check("t1 chg", {2'b0, bus.mode_change}, 3'b000);
    check("t1 err", {2'b0, bus.err_multi}, 3'b000);

    // 2: clean select of auto-play, commit on edge 10
    @(negedge clk) bus.sw_raw = AUTO_PLAY_MODE;
    edges(9);
    check("t2 sel e9", bus.mode_sel, WRONG_STATE);
    edges(1);
    check("t2 sel e10", bus.mode_sel, AUTO_PLAY_MODE);
    check("t2 chg e10", {2'b0, bus.mode_change}, 3'b001);
    edges(1);
    check("t2 chg e11", {2'b0, bus.mode_change}, 3'b000);

    // 3: 3-cycle glitch to free mode is filtered
    @(negedge clk) bus.sw_raw = FREE_MODE;
    edges(3);
    @(negedge clk) bus.sw_raw = AUTO_PLAY_MODE;
    edges(15);
    check("t3 sel", bus.mode_sel, AUTO_PLAY_MODE);

    // 4: multi-hot raises err and is ignored, then learning commits
    @(negedge clk) bus.sw_raw = 3'b011;
    edges(6);
    check("t4 err e6", {2'b0, bus.err_multi}, 3'b000);
    edges(1);
    check("t4 err e7", {2'b0, bus.err_multi}, 3'b001);
    check("t4 sel multi", bus.mode_sel, AUTO_PLAY_MODE);
    edges(5);
    @(negedge clk) bus.sw_raw = LEARNING_MODE;
    edges(9);
    check("t4 sel e9", bus.mode_sel, AUTO_PLAY_MODE);
    edges(1);
    check("t4 sel e10", bus.mode_sel, LEARNING_MODE);
    check("t4 chg e10", {2'b0, bus.mode_change}, 3'b001);

    // 5: locked change waits, then commits 4 edges after release
    @(negedge clk) begin
      bus.mode_lock = 1'b1;
      bus.sw_raw    = FREE_MODE;
    end
    edges(20);
    check("t5 sel locked", bus.mode_sel, LEARNING_MODE);
    @(negedge clk) bus.mode_lock = 1'b0;
    edges(3);
    check("t5 sel e3", bus.mode_sel, LEARNING_MODE);
    edges(1);
    check("t5 sel e4", bus.mode_sel, FREE_MODE);
    check("t5 chg e4", {2'b0, bus.mode_change}, 3'b001);

    // 5b: lock rising on the would-be commit edge aborts it
    @(negedge clk) bus.sw_raw = LEARNING_MODE;
    edges(9);
    @(negedge clk) bus.mode_lock = 1'b1;
    edges(1);
    check("t5b sel abort", bus.mode_sel, FREE_MODE);
    check("t5b chg abort", {2'b0, bus.mode_change}, 3'b000);
    edges(5);
    @(negedge clk) bus.mode_lock = 1'b0;
    edges(4);
    check("t5b sel rearm", bus.mode_sel, LEARNING_MODE);
    check("t5b chg rearm", {2'b0, bus.mode_change}, 3'b001);

    // 6: reset while arming clears everything, then a fresh commit
    @(negedge clk) bus.sw_raw = AUTO_PLAY_MODE;
    edges(8);
    @(negedge clk) rst = 1'b1;
    edges(1);
    check("t6 sel rst", bus.mode_sel, WRONG_STATE);
    check("t6 chg rst", {2'b0, bus.mode_change}, 3'b000);
    @(negedge clk) rst = 1'b0;
    edges(9);
    check("t6 sel e9", bus.mode_sel, WRONG_STATE);
    edges(1);
    check("t6 sel e10", bus.mode_sel, AUTO_PLAY_MODE);
    check("t6 chg e10", {2'b0, bus.mode_change}, 3'b001);

    edges(3);
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
